// File: rtl/segment_decode.sv
// Receive side of the BCD-to-7-segment path: captures an active-low segment pattern,
// waits for it to stay stable, decodes it to BCD and shifts accepted digits into a word.
module segment_decode #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned NUM_DIGITS    = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [6:0]                        segments,
    input  logic                              ready,
    output logic                              S0,
    output logic                              S1,
    output logic                              S2,
    output logic                              S3,
    output logic                              valid,
    output logic                              blank,
    output logic                              error,
    output logic [4*NUM_DIGITS-1:0]           bcd_word,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count
);

    localparam int unsigned CW  = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int unsigned BW  = 4 * NUM_DIGITS;
    localparam int unsigned DCW = $clog2(NUM_DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DECODE,
        WAIT_LOW
    } state_t;

    state_t          state_q, state_d;
    logic            ready_q;
    logic            rise;
    logic [6:0]      seg_q, seg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      digit_q, digit_d;
    logic            valid_d, blank_d, error_d;
    logic [BW-1:0]   word_d;
    logic [DCW-1:0]  count_d;

    logic [3:0]      lut_digit;
    logic            lut_hit;
    logic            lut_blank;

    assign rise = ready & ~ready_q;

    assign S0 = digit_q[3];
    assign S1 = digit_q[2];
    assign S2 = digit_q[1];
    assign S3 = digit_q[0];

    // Exact-match lookup of the held pattern; active-low bits {g,f,e,d,c,b,a}.
    always_comb begin
        lut_digit = '0;
        lut_hit   = 1'b1;
        lut_blank = 1'b0;
        case (seg_q)
            7'b1000000: lut_digit = 4'd0;
            7'b1111001: lut_digit = 4'd1;
            7'b0100100: lut_digit = 4'd2;
            7'b0110000: lut_digit = 4'd3;
            7'b0011001: lut_digit = 4'd4;
            7'b0010010: lut_digit = 4'd5;
            7'b0000010: lut_digit = 4'd6;
            7'b1111000: lut_digit = 4'd7;
            7'b0000000: lut_digit = 4'd8;
            7'b0011000: lut_digit = 4'd9;
            7'b1111111: begin
                lut_hit   = 1'b0;
                lut_blank = 1'b1;
            end
            default: lut_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        cnt_d   = cnt_q;
        digit_d = digit_q;
        word_d  = bcd_word;
        count_d = digit_count;
        valid_d = 1'b0;
        blank_d = 1'b0;
        error_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    seg_d   = segments;
                    cnt_d   = '0;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                // Dropping ready wins over a pattern change; any change restarts the count.
                if (!ready) begin
                    state_d = IDLE;
                end else if (segments != seg_q) begin
                    seg_d = segments;
                    cnt_d = '0;
                end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
                    state_d = DECODE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DECODE: begin
                state_d = WAIT_LOW;
                if (lut_hit) begin
                    digit_d = lut_digit;
                    word_d  = (bcd_word << 4) | BW'(lut_digit);
                    if (digit_count != DCW'(NUM_DIGITS)) begin
                        count_d = digit_count + DCW'(1);
                    end
                    valid_d = 1'b1;
                end else if (lut_blank) begin
                    blank_d = 1'b1;
                end else begin
                    error_d = 1'b1;
                end
            end
            WAIT_LOW: begin
                if (!ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ready_q resets high so a level already present at reset is not seen as a rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            seg_q       <= '0;
            cnt_q       <= '0;
            digit_q     <= '0;
            valid       <= 1'b0;
            blank       <= 1'b0;
            error       <= 1'b0;
            bcd_word    <= '0;
            digit_count <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready;
            seg_q       <= seg_d;
            cnt_q       <= cnt_d;
            digit_q     <= digit_d;
            valid       <= valid_d;
            blank       <= blank_d;
            error       <= error_d;
            bcd_word    <= word_d;
            digit_count <= count_d;
        end
    end

endmodule

// File: tb/tb_segment_decode.sv
// Randomized self-checking bench for segment_decode; expected pulse timing and the
// digit word come from a transaction-level model of the decode rules.
module tb_segment_decode;

    localparam int unsigned STABLE_CYCLES = 4;
    localparam int unsigned NUM_DIGITS    = 4;
    localparam int unsigned DCW           = $clog2(NUM_DIGITS + 1);
    localparam int          KIND_NONE     = -1;
    localparam int          KIND_BLANK    = 10;
    localparam int          KIND_ERROR    = 11;

    localparam logic [6:0] PAT [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
    };

    logic                    clk = 1'b0;
    logic                    reset;
    logic [6:0]              segments;
    logic                    ready;
    logic                    S0, S1, S2, S3;
    logic                    valid, blank, error;
    logic [4*NUM_DIGITS-1:0] bcd_word;
    logic [DCW-1:0]          digit_count;

    segment_decode #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .NUM_DIGITS   (NUM_DIGITS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .segments   (segments),
        .ready      (ready),
        .S0         (S0),
        .S1         (S1),
        .S2         (S2),
        .S3         (S3),
        .valid      (valid),
        .blank      (blank),
        .error      (error),
        .bcd_word   (bcd_word),
        .digit_count(digit_count)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         hist[$];
    logic [3:0] exp_dig;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int classify(input logic [6:0] p);
        int k;
        k = KIND_ERROR;
        if (p == 7'h7F) k = KIND_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (p == PAT[i]) k = i;
        end
        return k;
    endfunction

    function automatic logic [63:0] model_word();
        logic [63:0] w;
        w = '0;
        foreach (hist[i]) w = w * 16 + 64'(hist[i]);
        return w;
    endfunction

    task automatic model_reset();
        hist.delete();
        exp_dig = '0;
    endtask

    // Advance to the next falling edge and compare every output against the model.
    task automatic tick(input int kind);
        @(negedge clk);
        if (kind >= 0 && kind < 10) begin
            exp_dig = 4'(kind);
            hist.push_back(kind);
            if (hist.size() > NUM_DIGITS) void'(hist.pop_front());
        end
        check("valid", 64'(valid), 64'(kind >= 0 && kind < 10));
        check("blank", 64'(blank), 64'(kind == KIND_BLANK));
        check("error", 64'(error), 64'(kind == KIND_ERROR));
        check("digit", 64'({S0, S1, S2, S3}), 64'(exp_dig));
        check("bcd_word", 64'(bcd_word), model_word());
        check("digit_count", 64'(digit_count), 64'(hist.size()));
    endtask

    // One ready pulse: raised now, optional pattern change at offset c, dropped at offset h.
    // Decode happens only if ready survives the whole stable window after the last change.
    task automatic run_txn(input logic [6:0] seg0, input int c, input logic [6:0] seg1, input int h);
        int  kind, pj, n;
        bit  dec;
        kind = classify((c > 0) ? seg1 : seg0);
        dec  = (h >= c + int'(STABLE_CYCLES) + 1);
        pj   = c + int'(STABLE_CYCLES) + 2;
        n    = ((h > pj) ? h : pj) + 3;
        segments = seg0;
        ready    = 1'b1;
        for (int j = 1; j <= n; j++) begin
            tick((dec && j == pj) ? kind : KIND_NONE);
            if (c > 0 && j == c) segments = seg1;
            if (j == h) ready = 1'b0;
        end
    endtask

    function automatic logic [6:0] rand_pattern();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 7) return PAT[$urandom_range(0, 9)];
        if (r < 8) return 7'h7F;
        return 7'($urandom);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [6:0] s0, s1;
        int         c, h;

        reset    = 1'b1;
        ready    = 1'b0;
        segments = 7'h7F;
        model_reset();
        tick(KIND_NONE);
        tick(KIND_NONE);
        reset = 1'b0;
        tick(KIND_NONE);

        run_txn(7'b0110000, 0, 7'b0, 10);
        check("plan_first_word", 64'(bcd_word), 64'h0003);
        check("plan_first_count", 64'(digit_count), 64'd1);

        for (int d = 1; d <= 5; d++) run_txn(PAT[d], 0, 7'b0, 7);
        check("plan_seq_word", 64'(bcd_word), 64'h2345);
        check("plan_seq_count", 64'(digit_count), 64'd4);

        run_txn(7'b1111111, 0, 7'b0, 8);
        run_txn(7'b0101010, 0, 7'b0, 8);
        check("plan_hold_digit", 64'({S0, S1, S2, S3}), 64'h5);

        run_txn(7'b0000000, 2, 7'b0011000, 12);
        check("plan_change_digit", 64'({S0, S1, S2, S3}), 64'h9);
        run_txn(7'b1111001, 0, 7'b0, 2);

        ready = 1'b1;
        reset = 1'b1;
        model_reset();
        tick(KIND_NONE);
        tick(KIND_NONE);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) tick(KIND_NONE);
        ready = 1'b0;
        tick(KIND_NONE);
        tick(KIND_NONE);

        run_txn(7'b0011001, 0, 7'b0, 8);
        segments = 7'b0000010;
        ready    = 1'b1;
        tick(KIND_NONE);
        tick(KIND_NONE);
        reset = 1'b1;
        model_reset();
        tick(KIND_NONE);
        reset = 1'b0;
        ready = 1'b0;
        for (int i = 0; i < 4; i++) tick(KIND_NONE);
        check("plan_reset_word", 64'(bcd_word), 64'h0);
        run_txn(7'b0000010, 0, 7'b0, 8);

        run_txn(7'b1111000, 0, 7'b0, 20);
        check("plan_long_digit", 64'({S0, S1, S2, S3}), 64'h7);

        for (int t = 0; t < 150; t++) begin
            s0 = rand_pattern();
            s1 = s0;
            c  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, STABLE_CYCLES)) : 0;
            if (c > 0) begin
                do s1 = rand_pattern(); while (s1 == s0);
            end
            h = int'($urandom_range(1, 14));
            run_txn(s0, c, s1, h);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/segment_decode.md
Name: segment_decode

Overview:
- Receive side of the BCD-to-7-segment display path: accepts an active-low 7-segment pattern qualified by a `ready` strobe and recovers the BCD digit on S0..S3, with S0 as the MSB.
- Requires the pattern to be stable for a programmable number of clocks before decoding, then flags invalid or blank patterns.
- Shifts each accepted digit into a multi-digit BCD word used by the readback/checker logic of the coding system.

Parameters:
- STABLE_CYCLES, 4: consecutive clk cycles the captured pattern must stay unchanged before decoding; minimum 1.
- NUM_DIGITS, 4: depth of the BCD shift word in digits; minimum 1.

Ports:
- clk  input  1  system clock, all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- segments  input  7  active-low pattern, bit order {g,f,e,d,c,b,a}.
- ready  input  1  level strobe; a 0->1 transition, sampled on clk, starts one capture.
- S0  output  1  decoded digit bit 3 (MSB).
- S1  output  1  decoded digit bit 2.
- S2  output  1  decoded digit bit 1.
- S3  output  1  decoded digit bit 0 (LSB).
- valid  output  1  one-cycle pulse: a digit 0-9 was decoded.
- blank  output  1  one-cycle pulse: pattern 1111111 was decoded.
- error  output  1  one-cycle pulse: pattern matched no table entry.
- bcd_word  output  4*NUM_DIGITS  shift register of accepted digits; newest digit in bits [3:0].
- digit_count  output  clog2(NUM_DIGITS+1)  number of digits accepted; saturates at NUM_DIGITS.

Behaviour:
- Reset values: S0..S3=0, valid/blank/error=0, bcd_word=0, digit_count=0, FSM=IDLE, internal ready_q=1.
- ready_q resets to 1, so a `ready` level held high through reset does not start a capture.
- Rising edge detect: rise = ready & ~ready_q, with ready_q registered every cycle.
- Decode table, exact match required:
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4
  - 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0011000=9
  - 1111111=blank
  - anything else = error
- FSM states IDLE, CAPTURE, DECODE, WAIT_LOW:
  - IDLE: on rise, latch segments into seg_q, cnt=0, go to CAPTURE. Otherwise stay.
  - CAPTURE:
    - If ready=0, abort to IDLE; no outputs change.
    - Else if segments!=seg_q, reload seg_q and set cnt=0.
    - Else if cnt==STABLE_CYCLES-1, go to DECODE.
    - Else cnt++.
  - DECODE, one cycle: look up seg_q and register the results on the exiting edge, then go to WAIT_LOW.
    - digit: drive S0..S3; bcd_word <= {bcd_word[4*NUM_DIGITS-5:0], digit}; digit_count++ saturating; valid=1.
    - blank: blank=1; S0..S3, bcd_word and digit_count unchanged.
    - invalid: error=1; S0..S3, bcd_word and digit_count unchanged.
  - WAIT_LOW: stay until ready=0, then go to IDLE. Each ready pulse yields at most one decode.
- Pulses valid/blank/error are exactly one cycle wide and mutually exclusive. S0..S3 hold their value until the next valid.
- Latency, with segments stable: if edge E is the first to sample ready=1, the pulse is visible after edge E+STABLE_CYCLES+1 (edge E+5 at default).
- A segment change during CAPTURE restarts the stability count. Total latency becomes (last-change edge)+STABLE_CYCLES+1.
- Wrap: once digit_count==NUM_DIGITS, further digits still shift in; the oldest digit is discarded and the count stays at NUM_DIGITS.
- A new rise while in WAIT_LOW is impossible; ready must fall first, and a rise in DECODE is ignored.
- Reset mid-operation (any state) returns all registers to reset values on that edge. No pulse is emitted.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset, then ready 0->1 with segments=0110000 held for 10 cycles -> valid high for 1 cycle at edge E+5; {S0,S1,S2,S3}=0011; bcd_word=0x0003; digit_count=1.
- Sequence 1,2,3,4,5 (1111001, 0100100, 0110000, 0011001, 0010010), each with a separate ready pulse -> 5 valid pulses; final bcd_word=0x2345; digit_count=4 (saturated).
- segments=1111111 with ready pulse -> blank pulse; bcd_word unchanged. segments=0101010 -> error pulse; S0..S3 unchanged.
- Capture 0000000 and change it to 0011000 two cycles after the rise -> single valid with S=1001 (digit 9), 5 edges after the change. Separately, drop ready in CAPTURE -> no pulse, FSM back to IDLE.
- Hold ready high through reset, release reset -> no pulse. Assert reset during CAPTURE -> no pulse, bcd_word=0; the next clean ready pulse decodes normally.
- Keep ready high for 20 cycles with a stable 7 (1111000) -> exactly one valid pulse, S=0111.
